// File: rtl/asteroid_pkg.sv
// Shared types and the fixed spawn-origin table for the asteroid engine.
package asteroid_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    dir_t        dir;
  } origin_t;

  localparam origin_t ORIGIN_TABLE [8] = '{
    '{x: 16'd23,                   y: 16'd0,                    dir: DIR_DOWN},
    '{x: 16'd69,                   y: 16'd0,                    dir: DIR_DOWN},
    '{x: 16'd115,                  y: 16'd0,                    dir: DIR_DOWN},
    '{x: 16'(DEF_SCREEN_W - 1),    y: 16'd40,                   dir: DIR_LEFT},
    '{x: 16'd138,                  y: 16'(DEF_SCREEN_H - 1),    dir: DIR_UP},
    '{x: 16'd92,                   y: 16'(DEF_SCREEN_H - 1),    dir: DIR_UP},
    '{x: 16'd46,                   y: 16'(DEF_SCREEN_H - 1),    dir: DIR_UP},
    '{x: 16'd0,                    y: 16'd80,                   dir: DIR_RIGHT}
  };

  // Right-edge and bottom-edge origins follow the actual screen size.
  function automatic origin_t origin_of(logic [2:0] idx, int screen_w, int screen_h);
    origin_t o;
    o = ORIGIN_TABLE[idx];
    case (idx)
      3'd3:                o.x = 16'(screen_w - 1);
      3'd4, 3'd5, 3'd6:    o.y = 16'(screen_h - 1);
      default:             o = ORIGIN_TABLE[idx];
    endcase
    return o;
  endfunction

endpackage

// File: rtl/asteroid_slot.sv
// One asteroid slot: position, direction, step divider and active flag.
module asteroid_slot
  import asteroid_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int STEP_DIV = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           tick,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  input  dir_t           load_dir,
  input  logic           kill,
  output logic           active,
  output logic           active_next,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           escape
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [DIV_W-1:0] div, div_d;
  logic [X_W-1:0]   x_d;
  logic [Y_W-1:0]   y_d;
  dir_t             dir, dir_d;
  logic             escape_d;
  logic             at_edge;

  always_comb begin
    at_edge = 1'b0;
    case (dir)
      DIR_UP:    at_edge = (y == '0);
      DIR_DOWN:  at_edge = (y == Y_W'(SCREEN_H - 1));
      DIR_LEFT:  at_edge = (x == '0);
      DIR_RIGHT: at_edge = (x == X_W'(SCREEN_W - 1));
      default:   at_edge = 1'b0;
    endcase
  end

  // Load only targets a free slot and kill only an active one, so they never collide.
  always_comb begin
    active_next = active;
    x_d         = x;
    y_d         = y;
    dir_d       = dir;
    div_d       = div;
    escape_d    = 1'b0;
    if (load) begin
      active_next = 1'b1;
      x_d         = load_x;
      y_d         = load_y;
      dir_d       = load_dir;
      div_d       = '0;
    end else if (active) begin
      if (kill) begin
        active_next = 1'b0;
      end else if (tick) begin
        if (div == DIV_W'(STEP_DIV - 1)) begin
          div_d = '0;
          if (at_edge) begin
            active_next = 1'b0;
            escape_d    = 1'b1;
          end else begin
            case (dir)
              DIR_UP:    y_d = y - Y_W'(1);
              DIR_DOWN:  y_d = y + Y_W'(1);
              DIR_LEFT:  x_d = x - X_W'(1);
              DIR_RIGHT: x_d = x + X_W'(1);
              default:   x_d = x;
            endcase
          end
        end else begin
          div_d = div + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
      dir    <= DIR_UP;
      div    <= '0;
      escape <= 1'b0;
    end else begin
      active <= active_next;
      x      <= x_d;
      y      <= y_d;
      dir    <= dir_d;
      div    <= div_d;
      escape <= escape_d;
    end
  end

endmodule

// File: rtl/asteroid_field.sv
// Asteroid engine top: free-slot allocation, kill decode, escape OR and active popcount.
module asteroid_field
  import asteroid_pkg::*;
#(
  parameter int N_SLOTS  = 8,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int STEP_DIV = 1,
  localparam int SLOT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  localparam int CNT_W   = $clog2(N_SLOTS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 spawn_valid,
  input  logic [2:0]           spawn_origin,
  output logic                 spawn_ready,
  input  logic                 kill_valid,
  input  logic [SLOT_W-1:0]    kill_slot,
  output logic [N_SLOTS-1:0]   ast_active,
  output logic [N_SLOTS*X_W-1:0] ast_x,
  output logic [N_SLOTS*Y_W-1:0] ast_y,
  output logic                 escaped,
  output logic [CNT_W-1:0]     active_count
);

  logic [N_SLOTS-1:0] load_vec;
  logic [N_SLOTS-1:0] kill_vec;
  logic [N_SLOTS-1:0] next_vec;
  logic [N_SLOTS-1:0] esc_vec;
  logic [CNT_W-1:0]   count_d;
  origin_t            org;

  assign spawn_ready = |(~ast_active);
  assign org         = origin_of(spawn_origin, SCREEN_W, SCREEN_H);

  // Descending scan so the lowest-index free slot is the one left selected.
  always_comb begin
    load_vec = '0;
    if (spawn_valid) begin
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
        if (!ast_active[i]) begin
          load_vec    = '0;
          load_vec[i] = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
    assign kill_vec[gi] = kill_valid && (kill_slot == SLOT_W'(gi));

    asteroid_slot #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .STEP_DIV (STEP_DIV)
    ) u_slot (
      .clock       (clock),
      .reset       (reset),
      .tick        (tick),
      .load        (load_vec[gi]),
      .load_x      (X_W'(org.x)),
      .load_y      (Y_W'(org.y)),
      .load_dir    (org.dir),
      .kill        (kill_vec[gi]),
      .active      (ast_active[gi]),
      .active_next (next_vec[gi]),
      .x           (ast_x[gi*X_W +: X_W]),
      .y           (ast_y[gi*Y_W +: Y_W]),
      .escape      (esc_vec[gi])
    );
  end

  assign escaped = |esc_vec;

  // Count the post-edge flags so the registered count lines up with ast_active.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      count_d = count_d + CNT_W'(next_vec[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_count <= '0;
    end else begin
      active_count <= count_d;
    end
  end

endmodule

// File: tb/tb_asteroid_field.sv
// Scoreboard bench for asteroid_field: 4 slots at STEP_DIV=1, plus a STEP_DIV=3 twin.
module tb_asteroid_field;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;

  localparam int K_ACT   = 0;
  localparam int K_X     = 1;
  localparam int K_Y     = 2;
  localparam int K_READY = 3;
  localparam int K_COUNT = 4;
  localparam int K_ESC   = 5;
  localparam int K_Y3    = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic          spawn_valid = 1'b0;
  logic [2:0]    spawn_origin = 3'd0;
  logic          kill_valid = 1'b0;
  logic [1:0]    kill_slot = 2'd0;

  logic          spawn_ready, spawn_ready3;
  logic [N-1:0]  ast_active, ast_active3;
  logic [N*XW-1:0] ast_x, ast_x3;
  logic [N*YW-1:0] ast_y, ast_y3;
  logic          escaped, escaped3;
  logic [2:0]    active_count, active_count3;

  asteroid_field #(.N_SLOTS(N), .X_W(XW), .Y_W(YW), .SCREEN_W(160), .SCREEN_H(120), .STEP_DIV(1)) dut (
    .clock(clock), .reset(reset), .tick(tick), .spawn_valid(spawn_valid), .spawn_origin(spawn_origin),
    .spawn_ready(spawn_ready), .kill_valid(kill_valid), .kill_slot(kill_slot), .ast_active(ast_active),
    .ast_x(ast_x), .ast_y(ast_y), .escaped(escaped), .active_count(active_count)
  );

  asteroid_field #(.N_SLOTS(N), .X_W(XW), .Y_W(YW), .SCREEN_W(160), .SCREEN_H(120), .STEP_DIV(3)) dut3 (
    .clock(clock), .reset(reset), .tick(tick), .spawn_valid(spawn_valid), .spawn_origin(spawn_origin),
    .spawn_ready(spawn_ready3), .kill_valid(kill_valid), .kill_slot(kill_slot), .ast_active(ast_active3),
    .ast_x(ast_x3), .ast_y(ast_y3), .escaped(escaped3), .active_count(active_count3)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int          kind;
    int          slot;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] observe(input int kind, input int slot);
    case (kind)
      K_ACT:   return 32'(ast_active);
      K_X:     return 32'(ast_x[slot*XW +: XW]);
      K_Y:     return 32'(ast_y[slot*YW +: YW]);
      K_READY: return 32'(spawn_ready);
      K_COUNT: return 32'(active_count);
      K_ESC:   return 32'(escaped);
      K_Y3:    return 32'(ast_y3[slot*YW +: YW]);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input int slot, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.slot = slot; e.value = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(e.kind, e.slot), e.value);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    drain();
    tick = 1'b0;
    spawn_valid = 1'b0;
    kill_valid = 1'b0;
  endtask

  task automatic spawn(input logic [2:0] o);
    spawn_valid = 1'b1;
    spawn_origin = o;
  endtask

  task automatic kill(input logic [1:0] s);
    kill_valid = 1'b1;
    kill_slot = s;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #3;
    expect_val("rst_active", K_ACT, 0, 0);
    expect_val("rst_ready", K_READY, 0, 1);
    expect_val("rst_count", K_COUNT, 0, 0);
    expect_val("rst_escaped", K_ESC, 0, 0);
    drain();
    @(negedge clock);
    reset = 1'b1;
    expect_val("idle_active", K_ACT, 0, 0);
    expect_val("idle_ready", K_READY, 0, 1);
    expect_val("idle_count", K_COUNT, 0, 0);
    expect_val("idle_escaped", K_ESC, 0, 0);
    cycle();

    // spawn origin 1, three ticks on both divider settings
    spawn(3'd1);
    expect_val("sp1_active", K_ACT, 0, 4'b0001);
    expect_val("sp1_x", K_X, 0, 69);
    expect_val("sp1_y", K_Y, 0, 0);
    expect_val("sp1_count", K_COUNT, 0, 1);
    cycle();
    for (int k = 1; k <= 3; k++) begin
      tick = 1'b1;
      expect_val("div1_y", K_Y, 0, k);
      expect_val("div3_y", K_Y3, 0, (k == 3) ? 1 : 0);
      cycle();
    end
    kill(2'd0);
    expect_val("kill0_active", K_ACT, 0, 0);
    expect_val("kill0_escaped", K_ESC, 0, 0);
    expect_val("kill0_count", K_COUNT, 0, 0);
    cycle();

    // origin 7 flies right across the screen; spawning tick does not move it
    spawn(3'd7);
    tick = 1'b1;
    expect_val("sp7_x", K_X, 0, 0);
    expect_val("sp7_y", K_Y, 0, 80);
    cycle();
    for (int k = 1; k <= 159; k++) begin
      tick = 1'b1;
      expect_val("fly_x", K_X, 0, k);
      if (k == 159) begin
        expect_val("edge_active", K_ACT, 0, 4'b0001);
        expect_val("edge_escaped", K_ESC, 0, 0);
      end
      cycle();
    end
    tick = 1'b1;
    expect_val("exit_active", K_ACT, 0, 0);
    expect_val("exit_escaped", K_ESC, 0, 1);
    expect_val("exit_count", K_COUNT, 0, 0);
    cycle();
    expect_val("exit_pulse_end", K_ESC, 0, 0);
    cycle();

    // fill all four slots
    spawn(3'd0); expect_val("fill0", K_ACT, 0, 4'b0001); cycle();
    spawn(3'd3); expect_val("fill1", K_ACT, 0, 4'b0011); cycle();
    spawn(3'd4); expect_val("fill2", K_ACT, 0, 4'b0111); cycle();
    spawn(3'd7);
    expect_val("fill3", K_ACT, 0, 4'b1111);
    expect_val("full_ready", K_READY, 0, 0);
    expect_val("full_count", K_COUNT, 0, 4);
    expect_val("s0_x", K_X, 0, 23);
    expect_val("s1_x", K_X, 1, 159);
    expect_val("s1_y", K_Y, 1, 40);
    expect_val("s2_x", K_X, 2, 138);
    expect_val("s2_y", K_Y, 2, 119);
    expect_val("s3_y", K_Y, 3, 80);
    cycle();
    spawn(3'd5);
    expect_val("drop_active", K_ACT, 0, 4'b1111);
    expect_val("drop_count", K_COUNT, 0, 4);
    expect_val("drop_s2_x", K_X, 2, 138);
    expect_val("drop_s0_x", K_X, 0, 23);
    cycle();

    // kill and spawn together: freed slot not reusable this edge
    kill(2'd2);
    spawn(3'd5);
    expect_val("ks_active", K_ACT, 0, 4'b1011);
    expect_val("ks_count", K_COUNT, 0, 3);
    expect_val("ks_ready", K_READY, 0, 1);
    expect_val("ks_escaped", K_ESC, 0, 0);
    cycle();
    spawn(3'd5);
    expect_val("re_active", K_ACT, 0, 4'b1111);
    expect_val("re_x", K_X, 2, 92);
    expect_val("re_y", K_Y, 2, 119);
    expect_val("re_count", K_COUNT, 0, 4);
    cycle();

    for (int s = 0; s < 4; s++) begin
      kill(2'(s));
      cycle();
    end
    expect_val("clear_active", K_ACT, 0, 0);
    expect_val("clear_count", K_COUNT, 0, 0);
    kill(2'd1);
    expect_val("kill_idle_esc", K_ESC, 0, 0);
    cycle();

    // origin 2 down to the bottom row, then tick and kill together
    spawn(3'd2);
    expect_val("sp2_x", K_X, 0, 115);
    expect_val("sp2_y", K_Y, 0, 0);
    cycle();
    for (int k = 1; k <= 119; k++) begin
      tick = 1'b1;
      expect_val("fall_y", K_Y, 0, k);
      cycle();
    end
    expect_val("bottom_active", K_ACT, 0, 4'b0001);
    drain();
    tick = 1'b1;
    kill(2'd0);
    expect_val("tk_active", K_ACT, 0, 0);
    expect_val("tk_escaped", K_ESC, 0, 0);
    expect_val("tk_count", K_COUNT, 0, 0);
    cycle();
    expect_val("tk_escaped_next", K_ESC, 0, 0);
    cycle();

    // asynchronous reset in the middle of an active tick
    spawn(3'd4);
    expect_val("sp4_active", K_ACT, 0, 4'b0001);
    expect_val("sp4_count", K_COUNT, 0, 1);
    cycle();
    tick = 1'b1;
    spawn(3'd0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    expect_val("arst_active", K_ACT, 0, 0);
    expect_val("arst_x", K_X, 0, 0);
    expect_val("arst_y", K_Y, 0, 0);
    expect_val("arst_ready", K_READY, 0, 1);
    expect_val("arst_count", K_COUNT, 0, 0);
    expect_val("arst_escaped", K_ESC, 0, 0);
    drain();
    @(posedge clock);
    #1;
    expect_val("held_active", K_ACT, 0, 0);
    drain();
    tick = 1'b0;
    spawn_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
